// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge magnitude over a raster pixel stream with valid/ready handshakes.
// Optional macro SOBEL_THRESH_EN binarises the magnitude against THRESH.
module sobel_stream #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int THRESH = 128
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [PIX_W-1:0] in_pixel,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int MW = PIX_W + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [MW-1:0] PIX_MAX  = MW'((1 << PIX_W) - 1);

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [PIX_W-1:0] r_lb1 [IMG_W];
    logic [PIX_W-1:0] r_lb2 [IMG_W];
    // Two oldest window columns (c-2, c-1); the third column is the live incoming one.
    logic [PIX_W-1:0] r_win [3][2];

    logic             w_accept;
    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    logic [PIX_W-1:0] w_top;
    logic [PIX_W-1:0] w_mid;
    logic [PIX_W-1:0] w_p [3][3];
    logic             w_emit;
    logic             w_last;
    logic signed [MW-1:0] w_gx;
    logic signed [MW-1:0] w_gy;
    logic [MW-1:0]    w_ax;
    logic [MW-1:0]    w_ay;
    logic [MW-1:0]    w_mag;
    logic [PIX_W-1:0] w_out;

    function automatic logic signed [MW-1:0] sx(input logic [PIX_W-1:0] v);
        return signed'(MW'(v));
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // A start-of-frame pixel forces position (0,0) regardless of the counters.
    assign w_col = in_sof ? '0 : r_col;
    assign w_row = in_sof ? '0 : r_row;

    assign w_top  = r_lb2[w_col];
    assign w_mid  = r_lb1[w_col];
    assign w_emit = (w_row >= RW'(2)) && (w_col >= CW'(2));
    assign w_last = (w_row == ROW_LAST) && (w_col == COL_LAST);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_p[i][0] = r_win[i][0];
            w_p[i][1] = r_win[i][1];
        end
        w_p[0][2] = w_top;
        w_p[1][2] = w_mid;
        w_p[2][2] = in_pixel;
    end

    assign w_gx = (sx(w_p[0][2]) + (sx(w_p[1][2]) <<< 1) + sx(w_p[2][2]))
                - (sx(w_p[0][0]) + (sx(w_p[1][0]) <<< 1) + sx(w_p[2][0]));
    assign w_gy = (sx(w_p[2][0]) + (sx(w_p[2][1]) <<< 1) + sx(w_p[2][2]))
                - (sx(w_p[0][0]) + (sx(w_p[0][1]) <<< 1) + sx(w_p[0][2]));
    assign w_ax  = w_gx[MW-1] ? MW'(-w_gx) : MW'(w_gx);
    assign w_ay  = w_gy[MW-1] ? MW'(-w_gy) : MW'(w_gy);
    assign w_mag = w_ax + w_ay;

`ifdef SOBEL_THRESH_EN
    localparam logic [MW-1:0] THR = MW'(THRESH);
    assign w_out = (w_mag > THR) ? '1 : '0;
`else
    assign w_out = (w_mag > PIX_MAX) ? '1 : w_mag[PIX_W-1:0];
`endif

    // Line buffers are read-before-write at the same column and never reset.
    always_ff @(posedge CLOCK) begin
        if (w_accept) begin
            r_lb1[w_col] <= in_pixel;
            r_lb2[w_col] <= w_mid;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_col     <= '0;
            r_row     <= '0;
            out_pixel <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 2; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else begin
            if (w_accept) begin
                if (w_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= w_p[i][2];
                end
                out_valid <= w_emit;
                if (w_emit) begin
                    out_pixel <= w_out;
                    out_last  <= w_last;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x6 image: constant, edge, ramp, stall, sof, reset.
`timescale 1ns/1ps
module tb_sobel_stream;
  localparam int PIX_W  = 8;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 6;
  localparam int THRESH = 50;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [PIX_W-1:0] in_pixel = '0;
  logic             in_valid = 1'b0;
  logic             in_sof = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_valid;
  logic             out_last;
  logic             out_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [PIX_W:0] exp_q[$];
  logic [PIX_W:0] obs_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sobel_stream #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .THRESH(THRESH)
  ) dut (
    .CLOCK(clk), .RESET(rst),
    .in_pixel(in_pixel), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
  );

  // output monitor: records each handshake that will complete at the next rising edge
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) obs_q.push_back({out_last, out_pixel});
  end

  function automatic logic [PIX_W-1:0] pix_of(input int pat, input int r, input int c);
    if (pat == 0) return 8'd100;
    if (pat == 1) return (c < 4) ? 8'd0 : 8'd255;
    return PIX_W'(c * 10 + r * 0);
  endfunction

  // hand-derived centre values: constant 0, edge 255 at cols 3/4, ramp |Gx|=4*20=80
  function automatic logic [PIX_W-1:0] exp_of(input int pat, input int c);
    if (pat == 0) return 8'd0;
    if (pat == 1) return (c == 3 || c == 4) ? 8'd255 : 8'd0;
`ifdef SOBEL_THRESH_EN
    return 8'd255;
`else
    return 8'd80;
`endif
  endfunction

  task automatic push_frame_exp(input int pat);
    for (int r = 1; r <= IMG_H - 2; r++)
      for (int c = 1; c <= IMG_W - 2; c++)
        exp_q.push_back({(r == IMG_H - 2 && c == IMG_W - 2), exp_of(pat, c)});
  endtask

  // driver: present one pixel and wait (bounded) until it is accepted
  task automatic send_pixel(input logic [PIX_W-1:0] p, input logic sof);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_pixel = p;
    in_sof   = sof;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_sof = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: pixel %0d not accepted within 100 cycles, required acceptance", p);
    end
  endtask

  task automatic send_frame(input int pat, input logic sof_first, input logic check_lat, input string name);
    for (int k = 0; k < IMG_W * IMG_H; k++) begin
      send_pixel(pix_of(pat, k / IMG_W, k % IMG_W), sof_first && (k == 0));
      if (check_lat && k == 17) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_lat18: out_valid=%b after 18th pixel, required 0", name, out_valid);
        end
      end
      if (check_lat && k == 18) begin
        n_cmp++;
        if (out_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL %s_lat19: out_valid=%b after 19th pixel, required 1", name, out_valid);
        end
      end
    end
  endtask

  task automatic drain_check(input string name);
    logic [PIX_W:0] e;
    logic [PIX_W:0] o;
    int ne;
    int idx;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    ne = exp_q.size();
    for (int i = 0; i < 40 && obs_q.size() < ne; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_q.size() != ne) begin
      n_bad++;
      $display("FAIL %s_count: got %0d outputs, required %0d", name, obs_q.size(), ne);
    end
    idx = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s_out[%0d]: got last=%b pix=%0d, required last=%b pix=%0d",
                 name, idx, o[PIX_W], o[PIX_W-1:0], e[PIX_W], e[PIX_W-1:0]);
      end
      idx++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_idle(input string name);
    n_cmp++;
    if (out_valid !== 1'b0 || out_pixel !== 8'd0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: valid=%b pix=%0d last=%b in_ready=%b, required 0/0/0/1",
               name, out_valid, out_pixel, out_last, in_ready);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #3;
    check_idle("reset_asserted");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_idle("reset_released");
    @(posedge clk);
    #1;
  endtask

  task automatic test_constant();
    push_frame_exp(0);
    send_frame(0, 1'b1, 1'b1, "const");
    drain_check("const");
  endtask

  task automatic test_edge();
    push_frame_exp(1);
    send_frame(1, 1'b1, 1'b1, "edge");
    drain_check("edge");
  endtask

  task automatic test_ramp();
    push_frame_exp(2);
    send_frame(2, 1'b1, 1'b1, "ramp");
    drain_check("ramp");
  endtask

  task automatic test_back_to_back();
    push_frame_exp(2);
    push_frame_exp(1);
    send_frame(2, 1'b1, 1'b0, "b2b_a");
    send_frame(1, 1'b0, 1'b1, "b2b_b");
    drain_check("b2b");
  endtask

  task automatic test_stall();
    push_frame_exp(1);
    for (int k = 0; k < IMG_W * IMG_H; k++) begin
      send_pixel(pix_of(1, k / IMG_W, k % IMG_W), k == 0);
      if (k == 20) begin
        // pixel 21 completes centre (1,3), which is on the edge
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = pix_of(1, 2, 5);
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          n_cmp++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pixel !== 8'd255 || out_last !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold[%0d]: in_ready=%b valid=%b pix=%0d last=%b, required 0/1/255/0",
                     s, in_ready, out_valid, out_pixel, out_last);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    end
    drain_check("stall");
  endtask

  task automatic test_sof();
    exp_q.push_back({1'b0, exp_of(2, 1)});
    exp_q.push_back({1'b0, exp_of(2, 2)});
    push_frame_exp(1);
    for (int k = 0; k < 20; k++) send_pixel(pix_of(2, k / IMG_W, k % IMG_W), k == 0);
    send_frame(1, 1'b1, 1'b1, "sof");
    drain_check("sof");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 30; k++) send_pixel(pix_of(2, k / IMG_W, k % IMG_W), k == 0);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_pre: out_valid=%b after 30th pixel, required 1", out_valid);
    end
    rst = 1'b1;
    #1;
    check_idle("rstmid_async");
    @(posedge clk);
    #1 rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
    push_frame_exp(1);
    send_frame(1, 1'b0, 1'b1, "rstmid");
    drain_check("rstmid");
  endtask

  initial begin
    test_reset();
    test_constant();
    test_edge();
    test_ramp();
    test_back_to_back();
    test_stall();
    test_sof();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 8: pixel width in bits (4..16).
REQ-002 SHALL have parameter IMG_W, default 64: pixels per row (3..1024).
REQ-003 SHALL have parameter IMG_H, default 64: rows per frame (3..1024).
REQ-004 SHALL have parameter THRESH, default 128: binarisation threshold (used only under REQ-027).
REQ-005 SHALL have port CLOCK  input  1: single clock, rising edge.
REQ-006 SHALL have port RESET  input  1: asynchronous, active-high reset.
REQ-007 SHALL have port in_pixel  input  PIX_W: raster-order pixel, unsigned.
REQ-008 SHALL have port in_valid  input  1: in_pixel valid.
REQ-009 SHALL have port in_sof  input  1: start of frame; qualified by in_valid.
REQ-010 SHALL have port in_ready  output  1: block accepts input this cycle.
REQ-011 SHALL have port out_pixel  output  PIX_W: gradient magnitude.
REQ-012 SHALL have port out_valid  output  1: out_pixel valid.
REQ-013 SHALL have port out_last  output  1: last output of frame; qualified by out_valid.
REQ-014 SHALL have port out_ready  input  1: downstream accepts output.

Function
REQ-015 An input SHALL be accepted when in_valid and in_ready are both 1; an output SHALL be consumed when out_valid and out_ready are both 1.
REQ-016 in_ready SHALL equal (!out_valid || out_ready); a combinational path from out_ready to in_ready is permitted.
REQ-017 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), both advanced per accepted pixel; col wraps to 0 and increments row; row wraps from IMG_H-1 to 0, so consecutive frames need no in_sof.
REQ-018 An accepted pixel with in_sof=1 SHALL be treated as (row 0, col 0) regardless of counter state, abandoning any partial frame without emitting further outputs for it.
REQ-019 SHALL hold two line buffers of IMG_W x PIX_W (rows r-1 and r-2) and a 3x3 window register set, all updated only on accepted pixels; read-before-write at the same column.
REQ-020 A pixel accepted at (r,c) with r>=2 and c>=2 SHALL produce exactly one output for centre (r-1,c-1); other positions SHALL produce none; outputs per frame = (IMG_W-2)*(IMG_H-2).
REQ-021 Latency: out_valid SHALL assert on the cycle after the completing pixel is accepted.
REQ-022 Window p[i][j] (i=row 0..2 top-down, j=col 0..2 left-right): Gx=(p02+2p12+p22)-(p00+2p10+p20), Gy=(p20+2p21+p22)-(p00+2p01+p02), signed PIX_W+4 bits, no overflow.
REQ-023 mag=|Gx|+|Gy|; out_pixel SHALL be min(mag, 2^PIX_W-1).
REQ-024 out_last SHALL be 1 exactly for the output of centre (IMG_H-2, IMG_W-2).
REQ-025 While out_valid=1 and out_ready=0, out_pixel, out_last and out_valid SHALL be held stable and no input accepted.

Reset
REQ-026 RESET=1 SHALL asynchronously clear col, row, window registers, out_pixel, out_valid, out_last to 0; in_ready SHALL be 1 after release; line buffer contents need not be cleared; reset mid-frame discards the frame, next accepted pixel is (0,0).

Configuration
REQ-027 With macro SOBEL_THRESH_EN defined, out_pixel SHALL be 2^PIX_W-1 when mag > THRESH else 0; without it, out_pixel SHALL follow REQ-023 and THRESH SHALL be unused.

Verification (PIX_W=8, IMG_W=8, IMG_H=6)
REQ-028 Constant image 100, out_ready=1 -> 24 outputs, all 0, out_last only on 24th, first out_valid one cycle after 19th accepted pixel.
REQ-029 Vertical edge, cols 0-3=0, cols 4-7=255 -> centre cols 3,4 give 255 (mag 1020 saturated), all other centres 0.
REQ-030 Ramp pixel=col*10 -> every output 80; with SOBEL_THRESH_EN and THRESH=50 -> every output 255; THRESH=80 -> every output 0.
REQ-031 Constant stream, out_ready held 0 for 5 cycles while out_valid=1 -> in_ready=0, out_pixel stable, no pixel lost; output count still 24.
REQ-032 in_sof reasserted after 20 pixels of a frame -> counters restart, next output after 19th pixel of new frame, 24 outputs for new frame.
REQ-033 RESET pulsed after 30 pixels -> all outputs 0 immediately; following full frame yields 24 correct outputs.
